// File: rtl/eq_pkg.sv
// eq_pkg: shared state encoding, default sizes and saturating tap helper for the EQ tap bank
package eq_pkg;
   typedef enum logic [1:0] {IDLE, CALC, PUBLISH} eq_state_t;
   localparam int EQ_NBANDS = 4;
   localparam int EQ_GW = 4;
   localparam int EQ_TW = 16;
   function automatic logic [EQ_TW-1:0] sat_tap(input logic [EQ_GW-1:0] gain,
                                                input logic [EQ_TW-1:0] scale,
                                                input logic [EQ_TW-1:0] bias);
      logic [EQ_GW+EQ_TW:0] s;
      s = (EQ_GW+EQ_TW+1)'(gain) * (EQ_GW+EQ_TW+1)'(scale) + (EQ_GW+EQ_TW+1)'(bias);
      return |s[EQ_GW+EQ_TW:EQ_TW] ? '1 : s[EQ_TW-1:0];
   endfunction
endpackage

// File: rtl/eq_tap_calc.sv
// eq_tap_calc: scale, bias and saturate one band's gain code into a tap
module eq_tap_calc #(
   parameter int GW = 4,
   parameter int TW = 16,
   parameter logic [TW-1:0] SCALE = 1,
   parameter logic [TW-1:0] BIAS = 0
) (
   input  logic [GW-1:0] gain,
   output logic [TW-1:0] tap
);
   localparam int W = GW + TW + 1;
   logic [W-1:0] sum;
   // wide enough that the sum can never wrap, so any high bit means saturate
   assign sum = W'(gain) * W'(SCALE) + W'(BIAS);
   assign tap = |sum[W-1:TW] ? '1 : sum[TW-1:0];
endmodule

// File: rtl/eq_tap_bank.sv
// eq_tap_bank: computes one saturated tap per clock and publishes the whole set atomically
module eq_tap_bank
   import eq_pkg::*;
#(
   parameter int NBANDS = EQ_NBANDS,
   parameter int GW = EQ_GW,
   parameter int TW = EQ_TW,
   parameter logic [TW-1:0] SCALE = 1,
   parameter logic [TW-1:0] BIAS = 0,
   parameter bit AUTO = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [NBANDS*GW-1:0] eqVal,
   output logic [NBANDS*TW-1:0] allTaps,
   output logic [7:0]           tapnum,
   output logic                 busy,
   output logic                 taps_valid
);
   localparam logic [7:0] LAST = 8'(NBANDS - 1);
   eq_state_t st, nxt;
   logic [7:0] idx;
   logic [NBANDS*GW-1:0] eq_q, last_eq;
   logic [NBANDS*TW-1:0] shadow;
   logic [TW-1:0] tap;
   logic go;
   eq_tap_calc #(.GW(GW), .TW(TW), .SCALE(SCALE), .BIAS(BIAS)) u_calc (
      .gain(eq_q[idx*GW +: GW]),
      .tap (tap)
   );
   always_comb begin
      go = 1'b0;
      nxt = st;
      unique case (st)
         IDLE: begin
            go = start | (AUTO && eqVal != last_eq);
            nxt = go ? CALC : IDLE;
         end
         CALC: nxt = (idx == LAST) ? PUBLISH : CALC;
         PUBLISH: nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st <= IDLE;
         idx <= '0;
         eq_q <= '0;
         last_eq <= '0;
         shadow <= '0;
         allTaps <= '0;
         taps_valid <= 1'b0;
      end else begin
         st <= nxt;
         taps_valid <= st == PUBLISH;
         if (go) begin
            eq_q <= eqVal;
            last_eq <= eqVal;
            idx <= '0;
         end
         if (st == CALC) begin
            shadow[idx*TW +: TW] <= tap;
            idx <= idx + 8'd1;
         end
         // the filter only ever sees complete sets
         if (st == PUBLISH) allTaps <= shadow;
      end
   end
   assign busy = st != IDLE;
   assign tapnum = (st == CALC) ? idx : 8'd0;
endmodule

// File: doc/eq_tap_bank.md
# eq_tap_bank

Parametrised equalizer tap generator for the FPGA audio filter path. It takes a packed word of per-band gain codes and computes one saturated coefficient per band, one band per clock. The finished coefficient vector is published atomically to the recursive/FIR filter stage, with a start/busy/valid handshake and an optional auto-refresh when the gain word changes. It is the multi-band, handshaked successor of `all_taps`.

## Interface
- `NBANDS`, 4: number of EQ bands/taps; ≥2.
- `GW`, 4: gain-code width per band.
- `TW`, 16: tap width.
- `SCALE`, 1: unsigned multiplier applied to each gain code.
- `BIAS`, 0: unsigned offset added after scaling.
- `AUTO`, 0: when 1, a change of `eqVal` while idle starts a computation.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request a computation; sampled only in IDLE.
- `eqVal`  in  NBANDS*GW  packed gain codes; band k = `eqVal[k*GW +: GW]`, band 0 in LSBs.
- `allTaps`  out  NBANDS*TW  published taps; tap k = `allTaps[k*TW +: TW]`.
- `tapnum`  out  8  index of the band being computed; 0 when not in CALC.
- `busy`  out  1  high in CALC and PUBLISH.
- `taps_valid`  out  1  one-cycle pulse when `allTaps` updates.

## Operation
- States: IDLE, CALC, PUBLISH.
- **IDLE:**
  - On `start` = 1, or when `AUTO` = 1 and `eqVal` ≠ `last_eq`: latch `eqVal` into `eq_q`, update `last_eq`, set `idx` = 0, go to CALC.
- **CALC:**
  - Each cycle: `shadow[idx]` = sat(g_idx*SCALE + BIAS), where g_idx is taken from `eq_q`.
  - Increment `idx`. After `idx` = NBANDS−1, go to PUBLISH.
- **PUBLISH:**
  - `allTaps` ← `shadow`, `taps_valid` ← 1 for one cycle, go to IDLE.
- **Arithmetic:**
  - Product and sum are computed at width GW+TW+1, unsigned.
  - Results above 2^TW−1 saturate to 2^TW−1. There is no wrap-around.
- **Coherence:**
  - `allTaps` changes only in PUBLISH, so a partially computed set is never visible.
  - `eqVal` changes during CALC are ignored for the current set.
  - With AUTO = 1, a change during CALC is detected on return to IDLE, because `last_eq` holds the value latched at start.
- **Requests while busy:** `start` during CALC/PUBLISH is dropped, not queued.
- **Simultaneous requests:** `start` and an AUTO change in the same IDLE cycle produce a single computation.
- **Reset:** a mid-operation reset aborts the computation, clears `shadow`, and leaves `allTaps` at its reset value.

## Timing
- Reset values:
  - State = IDLE.
  - `allTaps` = 0, `tapnum` = 0, `busy` = 0, `taps_valid` = 0.
  - `idx` = 0, `eq_q` = 0, `last_eq` = 0.
- Start accepted on edge E0. `busy` is high from after E0 to after E(NBANDS+1).
- Band k is computed on edge E(k+1). `tapnum` = k during the cycle preceding that edge.
- `allTaps` and `taps_valid` update on edge E(NBANDS+1): latency is NBANDS+1 cycles (5 at defaults).
- Earliest next start is on the edge after PUBLISH. Throughput is one set per NBANDS+2 cycles.
- All outputs are registered. There are no combinational input-to-output paths.

## Structure
- Package `eq_pkg`:
  - State enum `eq_state_t` (IDLE, CALC, PUBLISH).
  - Default constants for NBANDS/GW/TW.
  - Function `sat_tap(gain, scale, bias)` returning a TW-bit saturated value.
- One natural sub-module, `eq_tap_calc`: combinational scale/bias/saturate of a single band.
  - `eq_tap_bank` instantiates it once and time-multiplexes it over bands using `idx`.

## Test plan
- Reset with `reset` pulsed asynchronously between edges → all outputs 0 immediately; state IDLE.
- Defaults, `eqVal` = 16'h7654, `start` one cycle → `tapnum` steps 0,1,2,3.
  - 5 cycles after the start edge: `allTaps` = 64'h0007_0006_0005_0004, `taps_valid` pulses once, then `busy` = 0.
- SCALE = 16'h2000, BIAS = 16'h0100, `eqVal` = 16'hF810 → taps {FFFF, FFFF, 2100, 0100}.
  - Bands 3 and 2 saturate; `allTaps` = 64'hFFFF_FFFF_2100_0100.
- `start` re-asserted and `eqVal` changed during CALC → no second computation.
  - The published set matches the `eqVal` latched at the first start.
- AUTO = 1: `eqVal` changes from 16'h7654 to 16'h1111 while idle with `start` = 0 → computation runs.
  - Result: `allTaps` = 64'h0001_0001_0001_0001.
  - Holding `eqVal` constant afterwards produces no further `taps_valid`.
- Reset asserted at the 2nd CALC cycle after a prior valid set → `allTaps` = 0, no `taps_valid`.
  - A subsequent `start` produces a correct complete set.
